// File: rtl/regfile_bypass_pkg.sv
// Shared constants and types for the bypassing register file.
// Holds register count, data width and index width used by every file of the block.
// Also provides the one-hot write decode helper.
package regfile_bypass_pkg;

    localparam int NUM_REGS = 8;
    localparam int DATA_W   = 16;
    localparam int IDX_W    = 3;

    typedef logic [DATA_W-1:0]   word_t;
    typedef logic [IDX_W-1:0]    idx_t;
    typedef logic [NUM_REGS-1:0] onehot_t;

    // 3-to-8 one-hot decode of a register index.
    function automatic onehot_t decode_onehot(input idx_t idx);
        onehot_t oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/regfile_bypass_cells.sv
// Leaf cells: reg16 (16-bit register, sync active-high reset, write enable)
// and sixteenmux8_1 (16-bit 8:1 combinational mux).
// Ports: reg16 clk/rst/en/d/q; sixteenmux8_1 in0..in7/sel/out.
module reg16 (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [15:0] d,
    output logic [15:0] q
);
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= 16'h0000;
        end else if (en) begin
            q <= d;
        end
    end
endmodule

module sixteenmux8_1 (
    input  logic [15:0] in0,
    input  logic [15:0] in1,
    input  logic [15:0] in2,
    input  logic [15:0] in3,
    input  logic [15:0] in4,
    input  logic [15:0] in5,
    input  logic [15:0] in6,
    input  logic [15:0] in7,
    input  logic [2:0]  sel,
    output logic [15:0] out
);
    always_comb begin
        out = in0;
        case (sel)
            3'd0: out = in0;
            3'd1: out = in1;
            3'd2: out = in2;
            3'd3: out = in3;
            3'd4: out = in4;
            3'd5: out = in5;
            3'd6: out = in6;
            3'd7: out = in7;
            default: out = in0;
        endcase
    end
endmodule

// File: rtl/regfile_bypass.sv
// Eight 16-bit registers, two combinational read ports with same-cycle write bypass.
// Ports: clk, rst (sync, active-high), read1RegSel/read2RegSel/writeRegSel, writeData,
// write, read1Data/read2Data, err (X/Z on control inputs, simulation only).
module regfile_bypass
    import regfile_bypass_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  read1RegSel,
    input  logic [2:0]  read2RegSel,
    input  logic [2:0]  writeRegSel,
    input  logic [15:0] writeData,
    input  logic        write,
    output logic [15:0] read1Data,
    output logic [15:0] read2Data,
    output logic        err
);

    word_t   regs_q [NUM_REGS];
    onehot_t wr_en;
    logic    wr_live;
    word_t   mux1_out;
    word_t   mux2_out;

    // Unknown control inputs can only be observed in a 4-state simulator;
    // a synthesized netlist has no X, so the flag is constant there.
`ifdef SYNTHESIS
    assign err = 1'b0;
`else
    assign err = $isunknown({write, writeRegSel, read1RegSel, read2RegSel});
`endif

    // A write is live only outside reset; it also drives the bypass path.
    assign wr_live = write & ~rst;

    // err blocks the store so corrupt controls never touch state.
    assign wr_en = decode_onehot(writeRegSel) & {NUM_REGS{wr_live & ~err}};

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_regs
        reg16 u_reg (
            .clk (clk),
            .rst (rst),
            .en  (wr_en[i]),
            .d   (writeData),
            .q   (regs_q[i])
        );
    end

    sixteenmux8_1 u_mux1 (
        .in0 (regs_q[0]), .in1 (regs_q[1]), .in2 (regs_q[2]), .in3 (regs_q[3]),
        .in4 (regs_q[4]), .in5 (regs_q[5]), .in6 (regs_q[6]), .in7 (regs_q[7]),
        .sel (read1RegSel),
        .out (mux1_out)
    );

    sixteenmux8_1 u_mux2 (
        .in0 (regs_q[0]), .in1 (regs_q[1]), .in2 (regs_q[2]), .in3 (regs_q[3]),
        .in4 (regs_q[4]), .in5 (regs_q[5]), .in6 (regs_q[6]), .in7 (regs_q[7]),
        .sel (read2RegSel),
        .out (mux2_out)
    );

    // Bypass: a reader of the register being written sees the new value this cycle.
    assign read1Data = (wr_live && (writeRegSel == read1RegSel)) ? writeData : mux1_out;
    assign read2Data = (wr_live && (writeRegSel == read2RegSel)) ? writeData : mux2_out;

endmodule

// File: tb/tb_regfile_bypass.sv
module tb_regfile_bypass;

    logic        clk;
    logic        rst;
    logic [2:0]  read1RegSel;
    logic [2:0]  read2RegSel;
    logic [2:0]  writeRegSel;
    logic [15:0] writeData;
    logic        write;
    logic [15:0] read1Data;
    logic [15:0] read2Data;
    logic        err;

    int n_checks = 0;
    int n_fails  = 0;

    // Reference: architectural register contents.
    logic [15:0] mdl [8];

    regfile_bypass dut (
        .clk         (clk),
        .rst         (rst),
        .read1RegSel (read1RegSel),
        .read2RegSel (read2RegSel),
        .writeRegSel (writeRegSel),
        .writeData   (writeData),
        .write       (write),
        .read1Data   (read1Data),
        .read2Data   (read2Data),
        .err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic exp_err();
        return $isunknown({write, writeRegSel, read1RegSel, read2RegSel});
    endfunction

    // Value a read port must show: the word being written if a live write
    // targets the same index, else the stored word.
    function automatic logic [15:0] exp_read(input logic [2:0] sel);
        if (write === 1'b1 && rst === 1'b0 && writeRegSel === sel)
            return writeData;
        return mdl[sel];
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        n_checks++;
        assert (obs === expv)
        else begin
            n_fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic check_all(input string tag);
        #2;
        chk({tag, ".rd1"}, read1Data, exp_read(read1RegSel));
        chk({tag, ".rd2"}, read2Data, exp_read(read2RegSel));
        chk({tag, ".err"}, {15'd0, err}, {15'd0, exp_err()});
    endtask

    // Advance one edge, applying the storage rules to the model.
    task automatic tick();
        if (rst === 1'b1) begin
            for (int k = 0; k < 8; k++) mdl[k] = 16'h0000;
        end else if (write === 1'b1 && !exp_err()) begin
            mdl[writeRegSel] = writeData;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [2:0] idx, input logic [15:0] val);
        write = 1'b1; writeRegSel = idx; writeData = val;
        tick();
        write = 1'b0;
    endtask

    initial begin
        rst = 1'b1; write = 1'b0; writeRegSel = 3'd0; writeData = 16'h0;
        read1RegSel = 3'd0; read2RegSel = 3'd0;
        for (int k = 0; k < 8; k++) mdl[k] = 16'h0000;
        @(posedge clk); #1;
        tick();
        rst = 1'b0;

        // Reset state on every index of both ports.
        for (int i = 0; i < 8; i++) begin
            read1RegSel = 3'(i); read2RegSel = 3'(7 - i);
            check_all("reset_read");
        end

        // Write then read back on both ports.
        read1RegSel = 3'd0; read2RegSel = 3'd1;
        do_write(3'd3, 16'hBEEF);
        read1RegSel = 3'd3; read2RegSel = 3'd3;
        check_all("r3_beef");
        chk("r3_beef.lit", read1Data, 16'hBEEF);

        // Same-cycle bypass, then stored value after the edge.
        do_write(3'd5, 16'h1234);
        write = 1'b1; writeRegSel = 3'd5; writeData = 16'hA5A5;
        read1RegSel = 3'd5; read2RegSel = 3'd3;
        check_all("bypass_r5");
        chk("bypass_r5.lit", read1Data, 16'hA5A5);
        tick();
        write = 1'b0;
        check_all("after_bypass_r5");
        chk("after_bypass_r5.lit", read1Data, 16'hA5A5);

        // Reset overrides a write and suppresses bypass.
        do_write(3'd2, 16'h5555);
        rst = 1'b1; write = 1'b1; writeRegSel = 3'd2; writeData = 16'hFFFF;
        read1RegSel = 3'd3; read2RegSel = 3'd2;
        check_all("rst_no_bypass");
        chk("rst_no_bypass.lit", read2Data, 16'h5555);
        tick();
        check_all("rst_held");
        rst = 1'b0; write = 1'b0;
        for (int i = 0; i < 8; i++) begin
            read1RegSel = 3'(i); read2RegSel = 3'(i);
            check_all("post_rst");
        end
        read2RegSel = 3'd2;
        #2 chk("r2_cleared.lit", read2Data, 16'h0000);

        // Distinct value in every register, then every read pair.
        for (int i = 0; i < 8; i++) do_write(3'(i), 16'(16'h1111 * (i + 1)));
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 8; j++) begin
                read1RegSel = 3'(i); read2RegSel = 3'(j);
                check_all("pair");
            end
        end

        // Random traffic with occasional reset.
        for (int n = 0; n < 300; n++) begin
            rst         = ($urandom_range(0, 15) == 0);
            write       = 1'($urandom_range(0, 1));
            writeRegSel = 3'($urandom_range(0, 7));
            writeData   = 16'($urandom_range(0, 65535));
            read1RegSel = 3'($urandom_range(0, 7));
            read2RegSel = ($urandom_range(0, 3) == 0) ? writeRegSel : 3'($urandom_range(0, 7));
            check_all("rand");
            tick();
        end
        rst = 1'b0; write = 1'b0;

        // Unknown write index: flag raised (where X exists) and no store.
        for (int i = 0; i < 8; i++) do_write(3'(i), 16'(16'h0F0F + i));
        read1RegSel = 3'd0; read2RegSel = 3'd1;
        write = 1'b1; writeData = 16'hDEAD; writeRegSel = 3'bx1x;
        #2 chk("x_sel.err", {15'd0, err}, {15'd0, exp_err()});
        tick();
        write = 1'b0; writeRegSel = 3'd0;
        for (int i = 0; i < 8; i++) begin
            read1RegSel = 3'(i); read2RegSel = 3'(7 - i);
            check_all("after_x");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
